// File: rtl/mips_fetch_pc_pkg.sv
// Shared definitions for the MIPS fetch/PC stage: datapath width, ALU opcodes
// and the fetch controller state encoding.
package mips_fetch_pc_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_SUB  = 4'd1,
        OP_BEQ  = 4'd2,
        OP_BNE  = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_AND  = 4'd6,
        OP_ANDI = 4'd7,
        OP_XOR  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTI = 4'd10,
        OP_NOP  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/mips_branch_target.sv
// Branch/jump target adder: word-aligned PC + 4 + (word offset << 2), modulo 2^WIDTH.
module mips_branch_target #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] br_pc_i,
    input  logic [WIDTH-1:0] br_imm_i,
    output logic [WIDTH-1:0] target_o
);

    // Low PC bits and the top two offset bits fall outside the word-scaled sum.
    logic unused_bits;
    assign unused_bits = ^{br_pc_i[1:0], br_imm_i[WIDTH-1:WIDTH-2]};

    assign target_o = {br_pc_i[WIDTH-1:2], 2'b00} + WIDTH'(4) + {br_imm_i[WIDTH-3:0], 2'b00};

endmodule

// File: rtl/mips_fetch_pc.sv
// Program counter and fetch-redirect controller with stall, halt and a
// saturating taken-branch counter. All outputs are registered.
//
// state | meaning
// BOOT  | one cycle after reset, no fetch
// RUN   | sequential fetch; handles halt > taken branch > stall
// FLUSH | one bubble after a redirect, pc already at target
// HALT  | fetch stopped until reset
module mips_fetch_pc
    import mips_fetch_pc_pkg::*;
#(
    parameter int               WIDTH    = DATA_W,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_pc,
    input  logic [WIDTH-1:0] br_imm,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] target;

    mips_branch_target #(.WIDTH(WIDTH)) u_target (
        .br_pc_i  (br_pc),
        .br_imm_i (br_imm),
        .target_o (target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (br_valid && br_taken) begin
                    state_d = ST_FLUSH;
                    pc_d    = target;
                    flush_d = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end else if (stall) begin
                    fetch_valid_d = 1'b1;
                end else begin
                    pc_d          = pc_q + WIDTH'(4);
                    fetch_valid_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The instruction in EX is wrong-path, so branch and stall are ignored here.
                if (halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
    assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_mips_fetch_pc.sv
// Directed vector bench for mips_fetch_pc: main table plus reset/halt/wrap/saturation sequences.
module tb_mips_fetch_pc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, halt = 1'b0, br_valid = 1'b0, br_taken = 1'b0;
    logic [31:0] br_pc = '0, br_imm = '0;

    logic [31:0] pc1, pc2;
    logic        fv1, fl1, fv2, fl2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mips_fetch_pc dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
        .pc(pc1), .fetch_valid(fv1), .flush(fl1), .taken_cnt(cnt1)
    );

    mips_fetch_pc #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
        .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
        .pc(pc2), .fetch_valid(fv2), .flush(fl2), .taken_cnt(cnt2)
    );

    typedef struct {
        logic        s, h, v, t;
        logic [31:0] bpc, bimm;
        logic [31:0] epc;
        logic        efv, efl;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, h, v, t, input logic [31:0] bpc, bimm,
                       input logic [31:0] epc, input logic efv, efl, input logic [15:0] ecnt);
        vec_t x;
        x.s = s; x.h = h; x.v = v; x.t = t; x.bpc = bpc; x.bimm = bimm;
        x.epc = epc; x.efv = efv; x.efl = efl; x.ecnt = ecnt;
        vecs.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, h, v, t, input logic [31:0] bpc, bimm);
        stall = s; halt = h; br_valid = v; br_taken = t; br_pc = bpc; br_imm = bimm;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [31:0] epc, input logic efv, efl,
                        input logic [15:0] ecnt);
        chk({tag, " pc"}, pc1, epc);
        chk({tag, " fetch_valid"}, 32'(fv1), 32'(efv));
        chk({tag, " flush"}, 32'(fl1), 32'(efl));
        chk({tag, " taken_cnt"}, 32'(cnt1), 32'(ecnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //  s  h  v  t  br_pc         br_imm        exp_pc        fv fl cnt
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'hC,        1, 0, 0);
        add(0, 0, 1, 1, 32'h4,        32'hFFFF_FFFE, 32'h0,       0, 1, 1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        1, 0, 1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        1, 0, 1);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h8,        1, 0, 1);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h8,        1, 0, 1);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h8,        1, 0, 1);
        add(1, 0, 1, 1, 32'd100,      32'd5,        32'd124,      0, 1, 2);
        add(1, 0, 1, 1, 32'd200,      32'd0,        32'd124,      1, 0, 2);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'd124,      1, 0, 2);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'd128,      1, 0, 2);
        add(0, 0, 1, 1, 32'h103,      32'h4000_0001, 32'h108,     0, 1, 3);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h108,      1, 0, 3);
        add(0, 0, 1, 0, 32'h0,        32'h0,        32'h10C,      1, 0, 3);
        add(0, 1, 1, 1, 32'h0,        32'd10,       32'h10C,      0, 0, 3);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h10C,      0, 0, 3);
        add(0, 0, 1, 1, 32'h0,        32'd10,       32'h10C,      0, 0, 3);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h10C,      0, 0, 3);

        repeat (2) @(posedge clk);
        #1;
        chk1("reset", 32'h0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s, vecs[i].h, vecs[i].v, vecs[i].t, vecs[i].bpc, vecs[i].bimm);
            step();
            chk1($sformatf("vec%0d", i), vecs[i].epc, vecs[i].efv, vecs[i].efl, vecs[i].ecnt);
        end

        // Asynchronous reset while in HALT, then restart from BOOT.
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk1("halt_rst", 32'h0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        chk1("reboot0", 32'h0, 1, 0, 0);
        step();
        chk1("reboot1", 32'h4, 1, 0, 0);

        // Halt arriving during the FLUSH bubble wins over returning to RUN.
        drive(0, 0, 1, 1, 32'h20, 32'd3);
        step();
        chk1("fl_halt_br", 32'h30, 0, 1, 1);
        drive(0, 1, 0, 0, 0, 0);
        step();
        chk1("fl_halt0", 32'h30, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk1("fl_halt1", 32'h30, 0, 0, 1);

        // Asynchronous reset in the middle of a FLUSH cycle.
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
        chk1("rst2_boot", 32'h0, 1, 0, 0);
        drive(0, 0, 1, 1, 32'h8, 32'd1);
        step();
        chk1("rst2_flush", 32'h10, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk1("rst2_async", 32'h0, 0, 0, 0);

        // Wrap at the top of the address space and counter saturation (CNT_W=2).
        chk("sat reset pc", pc2, 32'hFFFF_FFFC);
        chk("sat reset fv", 32'(fv2), 32'd0);
        #1 rst_n = 1'b1;
        step();
        chk("sat boot pc", pc2, 32'hFFFF_FFFC);
        chk("sat boot fv", 32'(fv2), 32'd1);
        step();
        chk("sat wrap pc", pc2, 32'h0);
        chk("sat wrap fv", 32'(fv2), 32'd1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, 1, 32'h0, 32'h0);
            step();
            chk($sformatf("sat br%0d pc", k), pc2, 32'h4);
            chk($sformatf("sat br%0d flush", k), 32'(fl2), 32'd1);
            chk($sformatf("sat br%0d cnt", k), 32'(cnt2), (k < 3) ? k + 1 : 3);
            drive(0, 0, 0, 0, 0, 0);
            step();
        end
        chk("wide cnt after 5", 32'(cnt1), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mips_fetch_pc.md
# mips_fetch_pc

Program-counter and fetch-redirect stage for the MIPS datapath, sitting directly upstream of the MIPS ALU. It generates the sequential fetch address and consumes the ALU's `br_taken` decision for resolved `beq`/`bne` instructions. On a taken branch it redirects the PC to the branch target, kills the wrong-path fetch with a flush pulse, and counts taken redirects. It also supports pipeline stall and a terminal halt.

## Interface
Parameters:
- `WIDTH`, 32, PC and operand width; matches the ALU `in1`/`in2`/`InstC` width.
- `RESET_PC`, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- `CNT_W`, 16, width of the taken-branch counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold the PC; downstream cannot accept a new fetch.
- `halt`  in  1  stop fetching permanently until reset.
- `br_valid`  in  1  the EX stage holds a resolved `beq`/`bne` this cycle.
- `br_taken`  in  1  ALU branch decision; meaningful only when `br_valid`=1.
- `br_pc`  in  WIDTH  address of the branch instruction in EX.
- `br_imm`  in  WIDTH  sign-extended word offset; the same value the ALU receives as `InstC`.
- `pc`  out  WIDTH  current fetch address.
- `fetch_valid`  out  1  `pc` is a live fetch request.
- `flush`  out  1  one-cycle pulse that kills the instructions in IF/ID.
- `taken_cnt`  out  CNT_W  number of redirects performed, saturating.

## Operation
- State machine with four states: BOOT, RUN, FLUSH, HALT. All outputs are registered.
- BOOT:
  - Entered on reset; lasts exactly one cycle.
  - `fetch_valid`=0.
  - Always transitions to RUN; `stall`, `halt` and `br_*` are ignored in BOOT.
- RUN: `fetch_valid`=1. Event priority per cycle, highest first:
  1. `halt`=1 → HALT. `pc` holds. `fetch_valid` and `flush` are 0 from the next cycle.
  2. `br_valid`&`br_taken` → FLUSH. `pc` ← target. `flush` ← 1. `taken_cnt` ← `taken_cnt`+1.
  3. `stall`=1 → `pc` holds; `fetch_valid` stays 1.
  4. Otherwise → `pc` ← `pc`+4.
- `br_valid`=1 with `br_taken`=0 behaves as no event; sequential fetch continues.
- FLUSH:
  - Lasts one cycle. `fetch_valid`=0, `flush`=1, `pc`=target.
  - Transitions to RUN unconditionally. `br_*` and `stall` are ignored, since the EX instruction is wrong-path.
  - `halt`=1 in FLUSH → HALT instead of RUN.
- HALT: absorbing state. `fetch_valid`=0, `flush`=0, `pc` frozen. Only `rst_n` exits.
- Arithmetic:
  - target = `{br_pc[WIDTH-1:2],2'b00}` + 4 + `{br_imm[WIDTH-3:0],2'b00}`, modulo 2^WIDTH.
  - `pc`+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC → 0).
  - `br_imm` bits above WIDTH-3 are discarded.
- `taken_cnt` saturates at all-ones and never wraps.

## Timing
- Reset values, applied asynchronously when `rst_n` falls: `pc`=RESET_PC, `fetch_valid`=0, `flush`=0, `taken_cnt`=0, state=BOOT.
- Reset applies immediately, including mid-FLUSH or mid-HALT. Release is synchronous to the next `clk` edge.
- First valid fetch at `pc`=RESET_PC appears in the cycle after BOOT (second cycle after reset release).
- Branch penalty:
  - `br_taken` is sampled at edge E.
  - Cycle after E: `flush`=1, `fetch_valid`=0, `pc`=target.
  - Following cycle: `fetch_valid`=1 at target.
  - One bubble per taken branch.
- A redirect overrides `stall` in the same cycle. During the following RUN cycles `stall` holds `pc`=target.
- `br_valid`=0 makes `br_taken`, `br_pc` and `br_imm` don't-care.

## Structure
- Shared include `mips_defs.v` holds:
  - the ALU opcode constants (Addi=0, sub=1, beq=2, bne=3, lw=4, sw=5, AND=6, ANDi=7, XOR=8, slt=9, slti=10, NOP=11);
  - the datapath width of 32;
  - the state encodings BOOT/RUN/FLUSH/HALT.
- Sub-module `mips_branch_target`: combinational adder producing target from `br_pc`/`br_imm`. It is instantiated once and reused by a later decode-stage jump path.

## Test plan
- Reset release with `RESET_PC`=0, no events → `pc` sequence 0,4,8,12; `fetch_valid` 0 for one cycle, then 1.
- At `pc`=12, `br_valid`=`br_taken`=1, `br_pc`=4, `br_imm`=32'hFFFF_FFFE (-2) → next cycle `pc`=0, `flush`=1, `fetch_valid`=0; then 0,4 with `fetch_valid`=1; `taken_cnt`=1.
- `stall`=1 for 3 cycles at `pc`=8, then a taken branch with `br_pc`=100, `br_imm`=5 during stall → `pc` holds 8, then jumps to 124.
- `br_valid`=1, `br_taken`=0 (in1=in2=5 with `bne`) → no flush; `pc` increments.
- `halt` and taken branch in the same cycle → HALT; `pc` frozen; `taken_cnt` unchanged. `rst_n` pulsed low in HALT → `pc`=0, BOOT.
- `pc`=32'hFFFF_FFFC advances to 0 (wrap). `CNT_W`=2 with 5 taken branches → `taken_cnt` stays at 3.
